// File: rtl/alu_seq16.sv
// 16-bit ALU sequencer: runs a 16-bit command as two byte passes through an external 8-bit jALU,
// chaining carry/shift bits between passes and merging the per-byte flags into 16-bit flags.
module alu_seq16 #(
    parameter int SETTLE = 0
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        co,
    output logic        alo,
    output logic        eqo,
    output logic        z,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_ci,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    input  logic        alu_eqo,
    input  logic        alu_alo,
    input  logic        alu_z
);

    typedef enum logic [2:0] {IDLE, P1, WAIT1, P2, WAIT2, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic        accept, cap1, cap2;
    logic        last_wait;

    logic [2:0]  op_q;
    logic [15:0] a_q, b_q;
    logic        ci_q;

    logic [7:0]  p1_out;
    logic        p1_co, p1_eq, p1_alo, p1_z;

    logic        hf;
    logic [15:0] res_next;
    logic        eq_hi, eq_lo, alo_hi, alo_lo;

    // SHR walks bits downward and CMP decides on the most significant byte, so both start high
    function automatic logic hi_first(input logic [2:0] o);
        return (o == 3'd1) || (o == 3'd7);
    endfunction

    function automatic logic chained(input logic [2:0] o);
        return (o == 3'd0) || (o == 3'd1) || (o == 3'd2);
    endfunction

    assign last_wait = (cnt == 8'(SETTLE - 1));
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? 8'd0 : cnt + 8'd1;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        cap1    = 1'b0;
        cap2    = 1'b0;
        case (state)
            IDLE:  if (start) begin accept = 1'b1; state_n = P1; end
            P1:    if (SETTLE == 0) begin cap1 = 1'b1; state_n = P2; end
                   else state_n = WAIT1;
            WAIT1: if (last_wait) begin cap1 = 1'b1; state_n = P2; end
            P2:    if (SETTLE == 0) begin cap2 = 1'b1; state_n = DONE; end
                   else state_n = WAIT2;
            WAIT2: if (last_wait) begin cap2 = 1'b1; state_n = DONE; end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pass-2 values come straight from the jALU on the capture edge; pass-1 values from registers
    always_comb begin
        hf       = hi_first(op_q);
        res_next = hf ? {p1_out, alu_out} : {alu_out, p1_out};
        eq_hi    = hf ? p1_eq   : alu_eqo;
        eq_lo    = hf ? alu_eqo : p1_eq;
        alo_hi   = hf ? p1_alo  : alu_alo;
        alo_lo   = hf ? alu_alo : p1_alo;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            op_q   <= 3'd0;
            a_q    <= 16'h0;
            b_q    <= 16'h0;
            ci_q   <= 1'b0;
            p1_out <= 8'h0;
            p1_co  <= 1'b0;
            p1_eq  <= 1'b0;
            p1_alo <= 1'b0;
            p1_z   <= 1'b0;
            alu_a  <= 8'h0;
            alu_b  <= 8'h0;
            alu_ci <= 1'b0;
            alu_op <= 3'd0;
            result <= 16'h0;
            co     <= 1'b0;
            alo    <= 1'b0;
            eqo    <= 1'b0;
            z      <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= op;
                a_q    <= a;
                b_q    <= b;
                ci_q   <= ci;
                alu_op <= op;
                alu_a  <= hi_first(op) ? a[15:8] : a[7:0];
                alu_b  <= hi_first(op) ? b[15:8] : b[7:0];
                alu_ci <= chained(op) ? ci : 1'b0;
            end
            if (cap1) begin
                p1_out <= alu_out;
                p1_co  <= alu_co;
                p1_eq  <= alu_eqo;
                p1_alo <= alu_alo;
                p1_z   <= alu_z;
                alu_a  <= hf ? a_q[7:0] : a_q[15:8];
                alu_b  <= hf ? b_q[7:0] : b_q[15:8];
                alu_ci <= chained(op_q) ? alu_co : 1'b0;
            end
            // Both byte zero flags set exactly when the 16-bit result is zero
            if (cap2) begin
                result <= res_next;
                co     <= chained(op_q) ? alu_co : 1'b0;
                eqo    <= eq_hi & eq_lo;
                alo    <= alo_hi | (eq_hi & alo_lo);
                z      <= p1_z & alu_z;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: behavioural jALU models behind two instances (SETTLE=0 and SETTLE=2),
// a directed vector table plus hand-written reset, handshake and settle sequences.
module tb_alu_seq16;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start0, start1;
    logic [2:0]  op_i;
    logic [15:0] a_i, b_i;
    logic        ci_i;

    logic        busy0, done0, co0, alo0, eqo0, z0;
    logic [15:0] result0;
    logic [7:0]  alu_a0, alu_b0, alu_out0;
    logic        alu_ci0, alu_co0, alu_eqo0, alu_alo0, alu_z0;
    logic [2:0]  alu_op0;

    logic        busy1, done1, co1, alo1, eqo1, z1;
    logic [15:0] result1;
    logic [7:0]  alu_a1, alu_b1, alu_out1;
    logic        alu_ci1, alu_co1, alu_eqo1, alu_alo1, alu_z1;
    logic [2:0]  alu_op1;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    alu_seq16 #(.SETTLE(0)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .start(start0), .op(op_i), .a(a_i), .b(b_i), .ci(ci_i),
        .busy(busy0), .done(done0), .result(result0), .co(co0), .alo(alo0), .eqo(eqo0), .z(z0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_ci(alu_ci0), .alu_op(alu_op0),
        .alu_out(alu_out0), .alu_co(alu_co0), .alu_eqo(alu_eqo0), .alu_alo(alu_alo0), .alu_z(alu_z0)
    );

    alu_seq16 #(.SETTLE(2)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .start(start1), .op(op_i), .a(a_i), .b(b_i), .ci(ci_i),
        .busy(busy1), .done(done1), .result(result1), .co(co1), .alo(alo1), .eqo(eqo1), .z(z1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_ci(alu_ci1), .alu_op(alu_op1),
        .alu_out(alu_out1), .alu_co(alu_co1), .alu_eqo(alu_eqo1), .alu_alo(alu_alo1), .alu_z(alu_z1)
    );

    // 8-bit jALU: returns {out, co, eqo, alo, z}; alo means A greater than B (unsigned)
    function automatic logic [11:0] jalu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
        logic [8:0] s;
        logic [7:0] r;
        logic       k;
        s = {1'b0, x} + {1'b0, y} + {8'd0, c};
        k = 1'b0;
        case (o)
            3'd0: begin r = s[7:0]; k = s[8]; end
            3'd1: begin r = {c, x[7:1]}; k = x[0]; end
            3'd2: begin r = {x[6:0], c}; k = x[7]; end
            3'd3: r = ~x;
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = x ^ y;
        endcase
        return {r, k, (x == y), (x > y), (r == 8'h0)};
    endfunction

    always_comb {alu_out0, alu_co0, alu_eqo0, alu_alo0, alu_z0} = jalu(alu_op0, alu_a0, alu_b0, alu_ci0);
    always_comb {alu_out1, alu_co1, alu_eqo1, alu_alo1, alu_z1} = jalu(alu_op1, alu_a1, alu_b1, alu_ci1);

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] res;
        logic        co;
        logic        eqo;
        logic        alo;
        logic        z;
        logic        chk_res;
        logic        chk_cmp;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for the chosen instance to be idle, issues one command, returns edges-from-accept to done
    task automatic applyStimulus(input logic sel, input logic [2:0] o, input logic [15:0] x,
                                 input logic [15:0] y, input logic c, output int lat);
        int k;
        lat = -1;
        k   = 0;
        @(negedge CLK);
        while ((sel ? (busy1 | done1) : (busy0 | done0)) && k < 20) begin
            @(negedge CLK);
            k++;
        end
        op_i = o; a_i = x; b_i = y; ci_i = c;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge CLK);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge CLK);
            #1;
            if (sel ? done1 : done0) begin
                lat = j + 1;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        logic saw_done;
        logic [15:0] hs_a[4];

        vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'd1, 16'h0100, 16'h0000, 1'b1, 16'h8080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'd2, 16'h8080, 16'h0000, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd1, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{3'd3, 16'h00FF, 16'h1234, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd4, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd5, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd6, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'd7, 16'h1200, 16'h11FF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'd7, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'd7, 16'h1233, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'd7, 16'h0034, 16'h0012, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        RSTN = 1'b0; start0 = 1'b0; start1 = 1'b0;
        op_i = 3'd0; a_i = 16'h0; b_i = 16'h0; ci_i = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset busy", {31'd0, busy0}, 32'd0);
        checkOutput("reset done", {31'd0, done0}, 32'd0);
        checkOutput("reset result", {16'd0, result0}, 32'd0);
        checkOutput("reset flags", {28'd0, co0, alo0, eqo0, z0}, 32'd0);
        checkOutput("reset alu drive", {12'd0, alu_a0, alu_b0, alu_ci0, alu_op0}, 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        // ADD with carry crossing bytes: watch the pass drive and the chained carry
        @(negedge CLK);
        op_i = 3'd0; a_i = 16'h00FF; b_i = 16'h0001; ci_i = 1'b0; start0 = 1'b1;
        @(posedge CLK); #1; start0 = 1'b0;
        checkOutput("add p1 busy", {31'd0, busy0}, 32'd1);
        checkOutput("add p1 alu_a", {24'd0, alu_a0}, 32'hFF);
        checkOutput("add p1 alu_ci", {31'd0, alu_ci0}, 32'd0);
        a_i = 16'h5555; b_i = 16'h5555;
        @(posedge CLK); #1;
        checkOutput("add p2 alu_a", {24'd0, alu_a0}, 32'h00);
        checkOutput("add p2 alu_ci", {31'd0, alu_ci0}, 32'd1);
        checkOutput("add p2 done", {31'd0, done0}, 32'd0);
        @(posedge CLK); #1;
        checkOutput("add done pulse", {31'd0, done0}, 32'd1);
        checkOutput("add done busy", {31'd0, busy0}, 32'd0);
        checkOutput("add result", {16'd0, result0}, 32'h0100);
        @(posedge CLK); #1;
        checkOutput("add done width", {31'd0, done0}, 32'd0);

        // Reset in the middle of pass 2 aborts without a done pulse
        @(negedge CLK);
        op_i = 3'd0; a_i = 16'h0F0F; b_i = 16'h0101; ci_i = 1'b1; start0 = 1'b1;
        @(posedge CLK); #1; start0 = 1'b0;
        @(posedge CLK); #2;
        RSTN = 1'b0;
        #1;
        checkOutput("rst busy", {31'd0, busy0}, 32'd0);
        checkOutput("rst result", {16'd0, result0}, 32'd0);
        checkOutput("rst flags", {28'd0, co0, alo0, eqo0, z0}, 32'd0);
        checkOutput("rst alu drive", {12'd0, alu_a0, alu_b0, alu_ci0, alu_op0}, 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        saw_done = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge CLK); #1;
            if (done0 | busy0) saw_done = 1'b1;
        end
        checkOutput("rst no done", {31'd0, saw_done}, 32'd0);
        checkOutput("rst result after", {16'd0, result0}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, lat);
            checkOutput($sformatf("v%0d latency", i), lat, 32'd3);
            checkOutput($sformatf("v%0d co", i), {31'd0, co0}, {31'd0, vecs[i].co});
            if (vecs[i].chk_res) begin
                checkOutput($sformatf("v%0d result", i), {16'd0, result0}, {16'd0, vecs[i].res});
                checkOutput($sformatf("v%0d z", i), {31'd0, z0}, {31'd0, vecs[i].z});
            end
            if (vecs[i].chk_cmp) begin
                checkOutput($sformatf("v%0d eqo", i), {31'd0, eqo0}, {31'd0, vecs[i].eqo});
                checkOutput($sformatf("v%0d alo", i), {31'd0, alo0}, {31'd0, vecs[i].alo});
            end
        end

        // start held high: one acceptance every 4 cycles, operands frozen at acceptance
        hs_a[0] = 16'h0010; hs_a[1] = 16'h0020; hs_a[2] = 16'h0030; hs_a[3] = 16'h0040;
        repeat (3) @(negedge CLK);
        op_i = 3'd0; b_i = 16'h0001; ci_i = 1'b0; a_i = hs_a[0]; start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            checkOutput($sformatf("hs%0d accepted", i), {31'd0, busy0}, 32'd1);
            a_i = hs_a[i+1];
            @(posedge CLK); #1;
            @(posedge CLK); #1;
            checkOutput($sformatf("hs%0d done", i), {31'd0, done0}, 32'd1);
            checkOutput($sformatf("hs%0d result", i), {16'd0, result0}, {16'd0, hs_a[i] + 16'h0001});
            @(posedge CLK); #1;
            checkOutput($sformatf("hs%0d ignored in done", i), {31'd0, busy0}, 32'd0);
        end
        start0 = 1'b0;

        // Two settle cycles per pass stretch the command to seven edges
        applyStimulus(1'b1, 3'd6, 16'hF0F0, 16'hFF00, 1'b0, lat);
        checkOutput("settle latency", lat, 32'd7);
        checkOutput("settle result", {16'd0, result1}, 32'h0FF0);
        checkOutput("settle z", {31'd0, z1}, 32'd0);
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 16'h0001, 1'b0, lat);
        checkOutput("settle add latency", lat, 32'd7);
        checkOutput("settle add result", {16'd0, result1}, 32'h0000);
        checkOutput("settle add co", {31'd0, co1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
